// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: parametrised, pipelined carry-lookahead adder/subtractor.
// Built from GROUP-bit lookahead blocks and a second-level group carry network.
// Operands enter through a valid/ready handshake and leave on a valid/ready
// handshake after STAGES register stages.
// Optional feature macro: CLA_STICKY_OVF_EN (sticky signed-overflow flag).
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable while valid is high and ready is low.
// ready may depend on out_ready and the stage valids, never on in_valid.
module cla_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam int NG = WIDTH / GROUP;

    // Group generate: G = g[n-1] | p[n-1]g[n-2] | ... | p[n-1]..p[1]g[0].
    function automatic logic [NG-1:0] grp_gen(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] g);
        logic [NG-1:0] r;
        logic          t;
        r = '0;
        for (int j = 0; j < NG; j++) begin
            for (int k = 0; k < GROUP; k++) begin
                t = g[j*GROUP+k];
                for (int m = k + 1; m < GROUP; m++) t = t & p[j*GROUP+m];
                r[j] = r[j] | t;
            end
        end
        return r;
    endfunction

    // Group propagate: AND of all bit propagates in the group.
    function automatic logic [NG-1:0] grp_prop(input logic [WIDTH-1:0] p);
        logic [NG-1:0] r;
        r = '0;
        for (int j = 0; j < NG; j++) r[j] = &p[j*GROUP +: GROUP];
        return r;
    endfunction

    // Second-level lookahead: carry into every group, plus the final carry out.
    function automatic logic [NG:0] grp_carry(input logic [NG-1:0] gg,
                                              input logic [NG-1:0] gp,
                                              input logic          c0);
        logic [NG:0] r;
        logic        t;
        logic        acc;
        r    = '0;
        r[0] = c0;
        for (int j = 1; j <= NG; j++) begin
            t = c0;
            for (int i = 0; i < j; i++) t = t & gp[i];
            acc = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                acc = acc | t;
            end
            r[j] = acc;
        end
        return r;
    endfunction

    // In-group lookahead from each group carry; bit WIDTH is the carry out.
    function automatic logic [WIDTH:0] bit_carry(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] g,
                                                 input logic [NG:0]      gc);
        logic [WIDTH:0] r;
        logic           t;
        logic           acc;
        r        = '0;
        r[WIDTH] = gc[NG];
        for (int j = 0; j < NG; j++) begin
            r[j*GROUP] = gc[j];
            for (int k = 1; k < GROUP; k++) begin
                t = gc[j];
                for (int m = 0; m < k; m++) t = t & p[j*GROUP+m];
                acc = t;
                for (int m = 0; m < k; m++) begin
                    t = g[j*GROUP+m];
                    for (int q = m + 1; q < k; q++) t = t & p[j*GROUP+q];
                    acc = acc | t;
                end
                r[j*GROUP+k] = acc;
            end
        end
        return r;
    endfunction

    // Front-end operand conditioning (shared by every stage partitioning).
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;

    assign b_eff = sub ? ~b : b;
    assign c0_in = sub ? 1'b1 : cin;
    assign p_in  = a ^ b_eff;
    assign g_in  = a & b_eff;

    // Pipeline control: a stage loads when it is empty or everything downstream moves.
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] load;

    for (genvar k = 0; k < STAGES; k++) begin : g_load
        assign load[k] = out_ready | ~(&vld[STAGES-1:k]);
    end

    assign in_ready  = load[0];
    assign out_valid = vld[STAGES-1];

    // Stage valid bits shift forward whenever the receiving stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            if (load[0]) vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) vld[k] <= vld[k-1];
            end
        end
    end

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    if (STAGES == 1) begin : g_s1
        logic [NG:0]    gc;
        logic [WIDTH:0] cr;
        assign gc = grp_carry(grp_gen(p_in, g_in), grp_prop(p_in), c0_in);
        assign cr = bit_carry(p_in, g_in, gc);

        // Single stage: full add computed from the inputs, only the result registered.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_r  <= '0;
                cout_r <= 1'b0;
                ovf_r  <= 1'b0;
            end else if (load[0]) begin
                sum_r  <= p_in ^ cr[WIDTH-1:0];
                cout_r <= cr[WIDTH];
                ovf_r  <= cr[WIDTH] ^ cr[WIDTH-1];
            end
        end
    end else begin : g_multi
        logic [WIDTH-1:0] s1_p;
        logic [WIDTH-1:0] s1_g;
        logic [NG-1:0]    s1_gg;
        logic [NG-1:0]    s1_gp;
        logic             s1_c0;
        logic             s1_amsb;

        // Stage 1: bit and group generate/propagate, MSB of a and carry-in.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_p    <= '0;
                s1_g    <= '0;
                s1_gg   <= '0;
                s1_gp   <= '0;
                s1_c0   <= 1'b0;
                s1_amsb <= 1'b0;
            end else if (load[0]) begin
                s1_p    <= p_in;
                s1_g    <= g_in;
                s1_gg   <= grp_gen(p_in, g_in);
                s1_gp   <= grp_prop(p_in);
                s1_c0   <= c0_in;
                s1_amsb <= a[WIDTH-1];
            end
        end

        logic [WIDTH-1:0] f_p;
        logic [WIDTH-1:0] f_g;
        logic [NG:0]      f_gc;
        logic             f_amsb;

        if (STAGES == 3) begin : g_s3
            logic [WIDTH-1:0] s2_p;
            logic [WIDTH-1:0] s2_g;
            logic [NG:0]      s2_gc;
            logic             s2_amsb;

            // Stage 2: resolve and register the group carries.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_p    <= '0;
                    s2_g    <= '0;
                    s2_gc   <= '0;
                    s2_amsb <= 1'b0;
                end else if (load[1]) begin
                    s2_p    <= s1_p;
                    s2_g    <= s1_g;
                    s2_gc   <= grp_carry(s1_gg, s1_gp, s1_c0);
                    s2_amsb <= s1_amsb;
                end
            end

            assign f_p    = s2_p;
            assign f_g    = s2_g;
            assign f_gc   = s2_gc;
            assign f_amsb = s2_amsb;
        end else begin : g_s2
            assign f_p    = s1_p;
            assign f_g    = s1_g;
            assign f_gc   = grp_carry(s1_gg, s1_gp, s1_c0);
            assign f_amsb = s1_amsb;
        end

        logic [WIDTH:0]   f_cr;
        logic [WIDTH-1:0] f_sum;
        logic             f_bmsb;
        assign f_cr   = bit_carry(f_p, f_g, f_gc);
        assign f_sum  = f_p ^ f_cr[WIDTH-1:0];
        // b_eff MSB recovered from p and a; operands of equal sign giving a
        // result of the other sign is the same as carry-in(MSB) ^ carry-out.
        assign f_bmsb = f_p[WIDTH-1] ^ f_amsb;

        // Final stage: sum, carry out and signed overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_r  <= '0;
                cout_r <= 1'b0;
                ovf_r  <= 1'b0;
            end else if (load[STAGES-1]) begin
                sum_r  <= f_sum;
                cout_r <= f_cr[WIDTH];
                ovf_r  <= (f_amsb ~^ f_bmsb) & (f_sum[WIDTH-1] ^ f_amsb);
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

`ifdef CLA_STICKY_OVF_EN
    logic sticky_r;

    // Sticky overflow: set by an emitted overflowing result, set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (out_valid && out_ready && ovf_r) begin
            sticky_r <= 1'b1;
        end else if (ovf_clr) begin
            sticky_r <= 1'b0;
        end
    end

    assign ovf_sticky = sticky_r;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe (WIDTH=8, GROUP=4, STAGES=2).
// Operands offered in cycle n give out_valid in cycle n+2.
module tb_cla_adder_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       ovf_sticky;
    logic       ovf_clr;

    int checks;
    int failures;

    cla_adder_pipe #(.WIDTH(8), .GROUP(4), .STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .sub        (sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time limit: report and stop if the sequence never completes.
    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                            input logic tsub);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
    endtask

    // One operation with out_ready=1: checks acceptance, latency, result, no duplicate.
    task automatic op_single(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                             input logic tcin, input logic tsub, input logic [7:0] es,
                             input logic ec, input logic eo);
        @(negedge clk);
        drive_op(ta, tb, tcin, tsub);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid_c1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid_c2"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        @(negedge clk);
        chk({tag, "_valid_after"}, out_valid, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sticky", ovf_sticky, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Add / subtract vectors
        op_single("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("sticky_after_noovf", ovf_sticky, 0);
        op_single("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
`ifdef CLA_STICKY_OVF_EN
        chk("sticky_set", ovf_sticky, 1);
`else
        chk("sticky_tied0", ovf_sticky, 0);
`endif
        op_single("add_00_00_c1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        op_single("add_a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        op_single("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op_single("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
        op_single("sub_3c_3c", 8'h3C, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
`ifdef CLA_STICKY_OVF_EN
        chk("sticky_hold", ovf_sticky, 1);
        // Clear pulse
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("sticky_clr", ovf_sticky, 0);
        // Clear held across an overflowing emit: set wins
        ovf_clr = 1'b1;
        op_single("add_7f_01_clr", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        chk("sticky_set_wins", ovf_sticky, 1);
        ovf_clr = 1'b0;
`else
        chk("sticky_still0", ovf_sticky, 0);
`endif

        // Backpressure: fill with out_ready=0, then drain while accepting
        out_ready = 1'b0;
        @(negedge clk);
        drive_op(8'h01, 8'h01, 1'b0, 1'b0);
        chk("bp_ready_1", in_ready, 1);
        @(negedge clk);
        drive_op(8'h02, 8'h02, 1'b0, 1'b0);
        chk("bp_ready_2", in_ready, 1);
        @(negedge clk);
        drive_op(8'h03, 8'h03, 1'b0, 1'b0);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_valid", out_valid, 1);
        chk("bp_full_sum", sum, 8'h02);
        @(negedge clk);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_sum", sum, 8'h02);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_through", in_ready, 1);
        @(negedge clk);
        chk("bp_out2_valid", out_valid, 1);
        chk("bp_out2_sum", sum, 8'h04);
        drive_op(8'h04, 8'h04, 1'b0, 1'b0);
        chk("bp_ready_4", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_out3_valid", out_valid, 1);
        chk("bp_out3_sum", sum, 8'h06);
        @(negedge clk);
        chk("bp_out4_valid", out_valid, 1);
        chk("bp_out4_sum", sum, 8'h08);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Reset with two operations in flight
        @(negedge clk);
        drive_op(8'h11, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive_op(8'h22, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_valid_before", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", out_valid, 0);
        chk("mid_async_sum", sum, 8'h00);
        chk("mid_async_sticky", ovf_sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_stale", out_valid, 0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
